// File: rtl/proc9_pkg.sv
// Shared definitions for the 9-bit processor control unit: opcodes,
// instruction-register field positions and the T-step state encoding.
package proc9_pkg;

    // Opcodes carried in IR[8:6]; anything with IR[8] set is unsupported.
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // IR = {III, XXX, YYY}
    localparam int III_MSB = 8;
    localparam int III_LSB = 6;
    localparam int XXX_MSB = 5;
    localparam int XXX_LSB = 3;
    localparam int YYY_MSB = 2;
    localparam int YYY_LSB = 0;

    // The low opcode bit distinguishes add (0) from sub (1).
    localparam int ADDSUB_BIT = 6;

    // Instruction steps; T0 is the fetch/idle step.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstate_e;

    // True for the two opcodes that need the A/G three-step sequence.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/proc9_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    // Drive exactly the selected line when enabled.
    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc9_control_unit.sv
// Control FSM for the 9-bit processor: fetches an instruction into IR on Run,
// then steps T1..T3 to drive register-file, A/G and bus-mux enables.
module proc9_control_unit #(
    parameter int DATA_W = 9,
    parameter int NREG   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic              IRin,
    output logic [NREG-1:0]   Rin,
    output logic [NREG-1:0]   Rout,
    output logic              DINout,
    output logic              Gout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done,
    output logic              Illegal,
    output logic              Busy
);

    import proc9_pkg::*;

    tstate_e           state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0] op;
    logic [2:0] x_sel;
    logic [2:0] y_sel;
    logic [7:0] x_hot;
    logic [7:0] y_hot;
    logic       dec_en;

    // Register-select enables chosen by the output decode below.
    logic rin_x;
    logic rout_x;
    logic rout_y;

    assign op     = ir_q[III_MSB:III_LSB];
    assign x_sel  = ir_q[XXX_MSB:XXX_LSB];
    assign y_sel  = ir_q[YYY_MSB:YYY_LSB];
    assign dec_en = (state_q != T0);

    dec3to8 u_dec_x (
        .en     (dec_en),
        .sel    (x_sel),
        .onehot (x_hot)
    );

    dec3to8 u_dec_y (
        .en     (dec_en),
        .sel    (y_sel),
        .onehot (y_hot)
    );

    // Next step and IR capture; Run only matters while waiting in T0.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            T0: begin
                if (Run) begin
                    state_d = T1;
                    ir_d    = DIN;
                end
            end
            T1:      state_d = is_alu_op(op) ? T2 : T0;
            T2:      state_d = T3;
            T3:      state_d = T0;
            default: state_d = T0;
        endcase
    end

    // State and IR registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Output decode from (step, IR); everything is forced low while reset is high.
    always_comb begin
        IRin    = 1'b0;
        DINout  = 1'b0;
        Gout    = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        Busy    = 1'b0;
        rin_x   = 1'b0;
        rout_x  = 1'b0;
        rout_y  = 1'b0;
        if (!reset) begin
            case (state_q)
                T0: begin
                    IRin = Run;
                end
                T1: begin
                    Busy = 1'b1;
                    case (op)
                        OP_MV: begin
                            rout_y = 1'b1;
                            rin_x  = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            rin_x  = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_x = 1'b1;
                            Ain    = 1'b1;
                        end
                        default: begin
                            Done    = 1'b1;
                            Illegal = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    Busy   = 1'b1;
                    rout_y = 1'b1;
                    Gin    = 1'b1;
                    AddSub = ir_q[ADDSUB_BIT];
                end
                T3: begin
                    Busy  = 1'b1;
                    Gout  = 1'b1;
                    rin_x = 1'b1;
                    Done  = 1'b1;
                end
                default: begin
                    Busy = 1'b0;
                end
            endcase
        end
        Rin  = rin_x ? x_hot : 8'h00;
        Rout = rout_x ? x_hot : (rout_y ? y_hot : 8'h00);
    end

endmodule

// File: tb/tb_proc9_control_unit.sv
// Self-checking bench for proc9_control_unit: directed instruction sequences
// with literal expectations plus a per-cycle comparison against an
// instruction-level model of the control sequence.
module tb_proc9_control_unit;

    logic       clock;
    logic       reset;
    logic       Run;
    logic [8:0] DIN;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       DINout;
    logic       Gout;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;
    logic       Illegal;
    logic       Busy;

    int total = 0;
    int bad   = 0;

    proc9_control_unit dut (
        .clock   (clock),
        .reset   (reset),
        .Run     (Run),
        .DIN     (DIN),
        .IRin    (IRin),
        .Rin     (Rin),
        .Rout    (Rout),
        .DINout  (DINout),
        .Gout    (Gout),
        .Ain     (Ain),
        .Gin     (Gin),
        .AddSub  (AddSub),
        .Done    (Done),
        .Illegal (Illegal),
        .Busy    (Busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packs the outputs as {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Busy}.
    function automatic logic [24:0] mk(input logic irin, input logic [7:0] rin, input logic [7:0] rout,
                                       input logic dinout, input logic gout, input logic ain,
                                       input logic gin, input logic addsub, input logic done,
                                       input logic illegal, input logic busy);
        return {irin, rin, rout, dinout, gout, ain, gin, addsub, done, illegal, busy};
    endfunction

    function automatic logic [24:0] dut_vec();
        return mk(IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Illegal, Busy);
    endfunction

    // Instruction-level model: which step of the current instruction we are in
    // (0 = waiting for fetch) and the fields of the fetched word.
    int         m_step = 0;
    logic [2:0] m_op   = 3'd0;
    logic [2:0] m_x    = 3'd0;
    logic [2:0] m_y    = 3'd0;

    // add and sub take three execute steps, everything else retires in one.
    function automatic int inst_len(input logic [2:0] op);
        return (op == 3'b010 || op == 3'b011) ? 3 : 1;
    endfunction

    // Expected outputs for a given step of an instruction.
    function automatic logic [24:0] model_out(input logic rst, input int stp, input logic [2:0] op,
                                              input logic [2:0] x, input logic [2:0] y, input logic run);
        logic [7:0] xh;
        logic [7:0] yh;
        xh = 8'd1 << x;
        yh = 8'd1 << y;
        if (rst) return 25'd0;
        case (stp)
            0: return mk(run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
            1: begin
                if (op == 3'b000)      return mk(0, xh, yh, 0, 0, 0, 0, 0, 1, 0, 1);
                else if (op == 3'b001) return mk(0, xh, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1);
                else if (op[2] == 1'b0) return mk(0, 8'h00, xh, 0, 0, 1, 0, 0, 0, 0, 1);
                else                   return mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1);
            end
            2: return mk(0, 8'h00, yh, 0, 0, 0, 1, op[0], 0, 0, 1);
            default: return mk(0, xh, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1);
        endcase
    endfunction

    // Advance the model on each rising edge from the sampled inputs.
    always @(posedge clock) begin
        if (reset) begin
            m_step <= 0;
        end else if (m_step == 0) begin
            if (Run) begin
                m_op   <= DIN[8:6];
                m_x    <= DIN[5:3];
                m_y    <= DIN[2:0];
                m_step <= 1;
            end
        end else if (m_step == inst_len(m_op)) begin
            m_step <= 0;
        end else begin
            m_step <= m_step + 1;
        end
    end

    // Per-cycle comparison against the model, plus the bus invariant.
    always @(negedge clock) begin
        logic [24:0] want;
        logic [24:0] got;
        logic [9:0]  drivers;
        want = model_out(reset, m_step, m_op, m_x, m_y, Run);
        got  = dut_vec();
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL model t=%0t: got %h want %h", $time, got, want);
        end
        drivers = {Rout, Gout, DINout};
        total++;
        if (!$onehot0(drivers) || !$onehot0(Rin)) begin
            bad++;
            $display("[TB] FAIL bus t=%0t: got drivers=%b rin=%b want at most one-hot", $time, drivers, Rin);
        end
    end

    // Drive inputs just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic run, input logic [8:0] din);
        @(posedge clock);
        #1;
        reset = r;
        Run   = run;
        DIN   = din;
    endtask

    // Compare outputs with a hand-computed literal on the following falling edge.
    task automatic checkOutput(input string name, input logic [24:0] want);
        logic [24:0] got;
        @(negedge clock);
        got = dut_vec();
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    localparam logic [24:0] ZERO  = 25'd0;
    localparam logic [24:0] FETCH = 25'h1000000;

    initial begin
        reset = 1'b1;
        Run   = 1'b1;
        DIN   = 9'd0;

        // Reset held two cycles with Run high: nothing may fire.
        checkOutput("reset_c0", ZERO);
        applyStimulus(1, 1, 9'd0);
        checkOutput("reset_c1", ZERO);
        applyStimulus(0, 0, 9'd0);
        checkOutput("idle_0", ZERO);
        applyStimulus(0, 0, 9'd0);
        checkOutput("idle_1", ZERO);

        // mvi R0,#5
        applyStimulus(0, 1, 9'b001_000_000);
        checkOutput("mvi_t0", FETCH);
        applyStimulus(0, 0, 9'd5);
        checkOutput("mvi_t1", mk(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("mvi_after", ZERO);

        // mv R3,R0
        applyStimulus(0, 1, 9'b000_011_000);
        checkOutput("mv_t0", FETCH);
        applyStimulus(0, 0, 9'd0);
        checkOutput("mv_t1", mk(0, 8'h08, 8'h01, 0, 0, 0, 0, 0, 1, 0, 1));

        // sub R1,R2 with Run held high, then a back-to-back mv R1,R2
        applyStimulus(0, 1, 9'b011_001_010);
        checkOutput("sub_t0", FETCH);
        applyStimulus(0, 0, 9'd0);
        checkOutput("sub_t1", mk(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0, 0, 1));
        applyStimulus(0, 1, 9'd0);
        checkOutput("sub_t2", mk(0, 8'h00, 8'h04, 0, 0, 0, 1, 1, 0, 0, 1));
        applyStimulus(0, 1, 9'b000_001_010);
        checkOutput("sub_t3", mk(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1));
        applyStimulus(0, 1, 9'b000_001_010);
        checkOutput("b2b_t0", FETCH);
        applyStimulus(0, 0, 9'd0);
        checkOutput("b2b_t1", mk(0, 8'h02, 8'h04, 0, 0, 0, 0, 0, 1, 0, 1));

        // add R7,R7 with Run dropped in T2
        applyStimulus(0, 1, 9'b010_111_111);
        checkOutput("add_t0", FETCH);
        applyStimulus(0, 1, 9'd0);
        checkOutput("add_t1", mk(0, 8'h00, 8'h80, 0, 0, 1, 0, 0, 0, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("add_t2", mk(0, 8'h00, 8'h80, 0, 0, 0, 1, 0, 0, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("add_t3", mk(0, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("add_idle", ZERO);

        // Unsupported opcode
        applyStimulus(0, 1, 9'b110_000_000);
        checkOutput("ill_t0", FETCH);
        applyStimulus(0, 0, 9'd0);
        checkOutput("ill_t1", mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("ill_after", ZERO);

        // add R2,R1 interrupted by reset in T3's cycle
        applyStimulus(0, 1, 9'b010_010_001);
        checkOutput("rst_mid_t0", FETCH);
        applyStimulus(0, 0, 9'd0);
        checkOutput("rst_mid_t1", mk(0, 8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("rst_mid_t2", mk(0, 8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 0, 1));
        applyStimulus(1, 0, 9'd0);
        checkOutput("rst_mid_hold", ZERO);
        applyStimulus(0, 0, 9'd0);
        checkOutput("rst_mid_after", ZERO);

        // sub R0,R0 after the aborted instruction
        applyStimulus(0, 1, 9'b011_000_000);
        checkOutput("sub0_t0", FETCH);
        applyStimulus(0, 0, 9'd0);
        checkOutput("sub0_t1", mk(0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("sub0_t2", mk(0, 8'h00, 8'h01, 0, 0, 0, 1, 1, 0, 0, 1));
        applyStimulus(0, 0, 9'd0);
        checkOutput("sub0_t3", mk(0, 8'h01, 8'h00, 0, 1, 0, 0, 0, 1, 0, 1));

        // Mixed instruction stream with mostly-high Run; the model checks each cycle.
        for (int i = 0; i < 64; i++) begin
            logic [8:0] w;
            w = {3'(i % 8), 3'((i * 3) % 8), 3'((i * 5 + 1) % 8)};
            applyStimulus(0, (i % 7) != 3, w);
        end
        applyStimulus(0, 0, 9'd0);
        applyStimulus(0, 0, 9'd0);
        applyStimulus(0, 0, 9'd0);
        applyStimulus(0, 0, 9'd0);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
